// File: rtl/ram_bus_master.sv
// Valid/ready initiator for the single-port strobed RAM: one transaction per strobe, response held until RSP_READY.
// Latency accept->RSP_VALID is 1+W (write) / 2+W (read); define MEMBUS_TIMEOUT_EN for a strobe-wait timeout (RSP_ERR).
module ram_bus_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SLOW_CLOCK_STRB,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              MEM_WRITE_EN,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_DATA_IN,
  input  logic [DATA_W-1:0] MEM_DATA_OUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_nxt, rsp_valid_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, rdata_nxt;

`ifdef MEMBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err, err_nxt;
  assign RSP_ERR = err;
`else
  assign RSP_ERR = 1'b0;
`endif

  assign REQ_READY = (state == IDLE) && !RESET;

  always_comb begin
    state_nxt     = state;
    we_nxt        = MEM_WRITE_EN;
    addr_nxt      = MEM_ADDRESS;
    wdata_nxt     = MEM_DATA_IN;
    rsp_valid_nxt = RSP_VALID;
    rdata_nxt     = RSP_RDATA;
`ifdef MEMBUS_TIMEOUT_EN
    cnt_nxt       = cnt;
    err_nxt       = err;
`endif
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          addr_nxt  = REQ_ADDR;
          wdata_nxt = REQ_WDATA;
          we_nxt    = REQ_WE;
          state_nxt = ISSUE;
`ifdef MEMBUS_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      ISSUE: begin
        // The RAM performs the access on this edge; a write is complete now.
        if (SLOW_CLOCK_STRB) begin
          we_nxt = 1'b0;
          if (MEM_WRITE_EN) begin
            rsp_valid_nxt = 1'b1;
            rdata_nxt     = '0;
            state_nxt     = RESP;
          end else begin
            state_nxt = CAPTURE;
          end
        end
`ifdef MEMBUS_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          we_nxt        = 1'b0;
          err_nxt       = 1'b1;
          rdata_nxt     = '0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      CAPTURE: begin
        rdata_nxt     = MEM_DATA_OUT;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
`ifdef MEMBUS_TIMEOUT_EN
          err_nxt       = 1'b0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      MEM_WRITE_EN <= 1'b0;
      MEM_ADDRESS  <= '0;
      MEM_DATA_IN  <= '0;
      RSP_VALID    <= 1'b0;
      RSP_RDATA    <= '0;
`ifdef MEMBUS_TIMEOUT_EN
      cnt          <= '0;
      err          <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      MEM_WRITE_EN <= we_nxt;
      MEM_ADDRESS  <= addr_nxt;
      MEM_DATA_IN  <= wdata_nxt;
      RSP_VALID    <= rsp_valid_nxt;
      RSP_RDATA    <= rdata_nxt;
`ifdef MEMBUS_TIMEOUT_EN
      cnt          <= cnt_nxt;
      err          <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Randomized bench for ram_bus_master: behavioural RAM on the MEM_* side, reference memory image per transaction.
module tb_ram_bus_master;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          SLOW_CLOCK_STRB;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_WDATA = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b0;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR;
  logic          MEM_WRITE_EN;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_DATA_IN;
  logic [DW-1:0] MEM_DATA_OUT;

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .SLOW_CLOCK_STRB(SLOW_CLOCK_STRB),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_WRITE_EN(MEM_WRITE_EN), .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA_IN(MEM_DATA_IN),
    .MEM_DATA_OUT(MEM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int strb_period = 4;
  int cyc = 0;
  int wr_cnt = 0;
  bit ram_loaded = 1'b0;
  logic [DW-1:0] ram     [0:255];
  logic [DW-1:0] exp_mem [0:255];

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 257) ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe: one CLK wide every strb_period cycles; period 0 holds it low.
  initial begin
    SLOW_CLOCK_STRB = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (strb_period > 0) SLOW_CLOCK_STRB = ((cyc % strb_period) == 0);
      else                 SLOW_CLOCK_STRB = 1'b0;
    end
  end

  // Behavioural RAM: acts only on strobe-qualified edges, registered read data.
  always @(posedge CLK) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (SLOW_CLOCK_STRB) begin
      if (MEM_WRITE_EN) begin
        ram[MEM_ADDRESS] <= MEM_DATA_IN;
        wr_cnt <= wr_cnt + 1;
      end
      MEM_DATA_OUT <= ram[MEM_ADDRESS];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int hold);
    int k, w, wr0, lat;
    bit got;
    logic [DW-1:0] exp_rd;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata;
    k = 0;
    while (!REQ_READY && k < 50) begin @(posedge CLK); #1; k++; end
    check("req_ready_idle", REQ_READY, 1);
    wr0 = wr_cnt;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    exp_rd = we ? '0 : exp_mem[addr];
    if (we) exp_mem[addr] = wdata;
    w = 0; k = 0; got = 1'b0;
    while (k < 200) begin
      k++;
      @(posedge CLK);
      if (w == 0 && SLOW_CLOCK_STRB) w = k;
      #1;
      if (RSP_VALID) begin got = 1'b1; break; end
    end
    check("rsp_arrived", got, 1);
    lat = we ? w : w + 1;
    check(we ? "wr_latency" : "rd_latency", k, lat);
    check("rsp_rdata", RSP_RDATA, exp_rd);
    check("rsp_err", RSP_ERR, 0);
    check("mem_we_after", MEM_WRITE_EN, 0);
    check("ram_write_count", wr_cnt - wr0, we ? 1 : 0);
    // Backpressure: a competing request must be ignored while the response waits.
    for (int h = 0; h < hold; h++) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = addr ^ 8'h01; REQ_WDATA = 16'hDEAD;
      @(posedge CLK); #1;
      check("hold_rsp_valid", RSP_VALID, 1);
      check("hold_rsp_rdata", RSP_RDATA, exp_rd);
      check("hold_req_ready", REQ_READY, 0);
      check("hold_mem_addr", MEM_ADDRESS, addr);
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    check("rsp_valid_cleared", RSP_VALID, 0);
    check("req_ready_back", REQ_READY, 1);
  endtask

  initial begin
    int k, nmis;
    bit got;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);

    repeat (3) @(posedge CLK);
    #1;
    check("reset_req_ready", REQ_READY, 0);
    check("reset_rsp_valid", RSP_VALID, 0);
    check("reset_rsp_rdata", RSP_RDATA, 0);
    check("reset_rsp_err", RSP_ERR, 0);
    check("reset_mem_we", MEM_WRITE_EN, 0);
    check("reset_mem_addr", MEM_ADDRESS, 0);
    check("reset_mem_din", MEM_DATA_IN, 0);
    RESET = 1'b0;
    #1;
    check("post_reset_ready", REQ_READY, 1);

    strb_period = 4;
    txn(1'b1, 8'h12, 16'hBEEF, 0);
    check("ram_12", ram[8'h12], 16'hBEEF);
    txn(1'b0, 8'h12, 16'h0000, 5);

    txn(1'b1, 8'hFF, 16'hC0DE, 0);
    txn(1'b0, 8'h00, 16'h0000, 0);
    check("ram_ff", ram[8'hFF], 16'hC0DE);
    check("ram_00", ram[8'h00], init_val(0));

    // Reset while a write waits in ISSUE: nothing may reach the RAM and no response.
    strb_period = 0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 8'h40; REQ_WDATA = 16'h1234;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    check("issue_mem_we", MEM_WRITE_EN, 1);
    RESET = 1'b1;
    #1;
    check("reset_req_ready_low", REQ_READY, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("abort_mem_we", MEM_WRITE_EN, 0);
    strb_period = 3;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (RSP_VALID) got = 1'b1;
    end
    check("abort_no_rsp", got, 0);
    check("abort_ram_40", ram[8'h40], exp_mem[8'h40]);
    check("abort_ready", REQ_READY, 1);

`ifdef MEMBUS_TIMEOUT_EN
    strb_period = 0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 8'h33;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    k = 0; got = 1'b0;
    while (k < 100) begin
      k++;
      @(posedge CLK); #1;
      if (RSP_VALID) begin got = 1'b1; break; end
    end
    check("to_rsp_arrived", got, 1);
    check("to_latency", k, TO);
    check("to_err", RSP_ERR, 1);
    check("to_rdata", RSP_RDATA, 0);
    check("to_mem_we", MEM_WRITE_EN, 0);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    check("to_err_cleared", RSP_ERR, 0);
    check("to_valid_cleared", RSP_VALID, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      strb_period = $urandom_range(1, 6);
      txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), DW'($urandom),
          $urandom_range(0, 2));
    end

    nmis = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) nmis++;
    check("ram_image", nmis, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
